// File: rtl/reg8_arb_pkg.sv
// Shared types and constants for the 8-bit register write arbiter.
package reg8_arb_pkg;

    localparam int unsigned REG_DATA_W = 8;

    // IDLE: round-robin arbitration; LOCKED: grant held by the burst owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: grants the first set request found when
// scanning ptr_i, ptr_i+1, ... wrapping modulo N.
// Ports:
//   req_i  [N]      request vector
//   ptr_i  [PTR_W]  index with highest priority (must be < N)
//   gnt_o  [N]      one-hot grant, zero when no request
//   idx_o  [PTR_W]  index of the granted request (0 when none)
//   any_o           at least one request present
module rr_priority_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned j;

    // Scan from ptr_i; the first hit wins and later hits are ignored.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!any_o && req_i[PTR_W'(j)]) begin
                any_o              = 1'b1;
                idx_o              = PTR_W'(j);
                gnt_o[PTR_W'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among N_REQ
// requesters, with locked bursts and a one-cycle registered write stage.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     per-requester write pending
//   req_addr      per-requester register address (slice i = requester i)
//   req_data      per-requester write data (slice i = requester i)
//   req_lock      per-requester: keep the grant after this beat
//   req_ready     one-hot grant (combinational); beat accepted on valid&ready
//   reg_we        one-hot register write enable, one cycle after accept
//   reg_wdata     write data, held between writes
//   err_oor       one-cycle pulse: accepted beat addressed beyond N_REG
//   busy_locked   arbiter is holding a locked grant
module reg8_write_arbiter
    import reg8_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_REG  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_W-1:0]       req_addr,
    input  logic [N_REQ*REG_DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_lock,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REG-1:0]              reg_we,
    output logic [REG_DATA_W-1:0]         reg_wdata,
    output logic                          err_oor,
    output logic                          busy_locked
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [N_REG-1:0]        reg_we_q, reg_we_d;
    logic [REG_DATA_W-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    logic [N_REQ-1:0]        pick_req;
    logic [N_REQ-1:0]        pick_gnt;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_any;

    logic [PTR_W-1:0]        gnt_idx;
    logic                    accept;
    logic [ADDR_W-1:0]       beat_addr;
    logic [REG_DATA_W-1:0]   beat_data;
    logic                    beat_lock;

    // The picker only sees requests while arbitrating freely.
    assign pick_req = (state_q == IDLE) ? req_valid : '0;

    rr_priority_picker #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grant: picker result in IDLE, owner only (if valid) while LOCKED.
    always_comb begin
        req_ready = '0;
        gnt_idx   = pick_idx;
        accept    = pick_any;
        if (state_q == LOCKED) begin
            gnt_idx            = owner_q;
            accept             = req_valid[owner_q];
            req_ready[owner_q] = req_valid[owner_q];
        end else begin
            req_ready = pick_gnt;
        end
    end

    // Select the granted requester's beat.
    always_comb begin
        beat_addr = '0;
        beat_data = '0;
        beat_lock = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                beat_addr = req_addr[i*ADDR_W +: ADDR_W];
                beat_data = req_data[i*REG_DATA_W +: REG_DATA_W];
                beat_lock = req_lock[i];
            end
        end
    end

    // Next-state: arbitration pointer, lock ownership and the write stage.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        reg_we_d = '0;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        if (accept) begin
            for (int unsigned r = 0; r < N_REG; r++) begin
                reg_we_d[r] = (beat_addr == ADDR_W'(r));
            end
            // No enable bit matched: address lies beyond the bank.
            err_d    = ~(|reg_we_d);
            wdata_d  = beat_data;
            rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (beat_lock) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d = IDLE;
            end
        end
        busy_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            reg_we_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            reg_we_q <= reg_we_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign reg_we      = reg_we_q;
    assign reg_wdata   = wdata_q;
    assign err_oor     = err_q;
    assign busy_locked = busy_q;

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Self-checking bench for reg8_write_arbiter (N_REQ=4, N_REG=5, ADDR_W=3):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_reg8_write_arbiter;

    localparam int NQ = 4;
    localparam int NG = 5;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NQ-1:0]     req_valid;
    logic [NQ*AW-1:0]  req_addr;
    logic [NQ*8-1:0]   req_data;
    logic [NQ-1:0]     req_lock;
    logic [NQ-1:0]     req_ready;
    logic [NG-1:0]     reg_we;
    logic [7:0]        reg_wdata;
    logic              err_oor;
    logic              busy_locked;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_ptr, m_locked, m_owner;
    int e_we, e_wdata, e_err;
    int last_ready;

    reg8_write_arbiter #(.N_REQ(NQ), .N_REG(NG), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .err_oor     (err_oor),
        .busy_locked (busy_locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0;
        e_we = 0; e_wdata = 0; e_err = 0;
    endtask

    // Who should be granted this cycle (-1 = nobody).
    function automatic int model_grant();
        if (m_locked != 0) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NQ; k++) begin
            if (req_valid[(m_ptr + k) % NQ]) return (m_ptr + k) % NQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int a, input int d, input bit l);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*8 +: 8]  = 8'(d);
        req_lock[i]         = l;
    endtask

    task automatic clear_all();
        req_valid = '0; req_addr = '0; req_data = '0; req_lock = '0;
    endtask

    // One clock with inputs already applied: checks grant, advances the
    // model, then checks the registered outputs after the edge.
    task automatic tick();
        int g, a;
        #2;
        g = model_grant();
        last_ready = int'(req_ready);
        check_eq("ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        if (g >= 0) begin
            a       = int'(req_addr[g*AW +: AW]);
            e_we    = (a < NG) ? (1 << a) : 0;
            e_err   = (a >= NG) ? 1 : 0;
            e_wdata = int'(req_data[g*8 +: 8]);
            m_ptr   = (g + 1) % NQ;
            if (req_lock[g]) begin
                m_locked = 1;
                m_owner  = g;
            end else begin
                m_locked = 0;
            end
        end else begin
            e_we  = 0;
            e_err = 0;
        end
        @(posedge clk);
        #1;
        check_eq("reg_we", 32'(reg_we), 32'(e_we));
        check_eq("reg_wdata", 32'(reg_wdata), 32'(e_wdata));
        check_eq("err_oor", 32'(err_oor), 32'(e_err));
        check_eq("busy_locked", 32'(busy_locked), 32'(m_locked));
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        model_reset();
        last_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(reg_we), 32'd0);
        check_eq("rst_wdata", 32'(reg_wdata), 32'd0);
        check_eq("rst_err", 32'(err_oor), 32'd0);
        check_eq("rst_busy", 32'(busy_locked), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Round robin across all four requesters
        for (int i = 0; i < NQ; i++) set_req(i, 1'b1, i, 8'hA0 + i, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rr_gnt", 32'(last_ready), 32'(1 << (k % 4)));
            check_eq("rr_we", 32'(reg_we), 32'(1 << (k % 4)));
            check_eq("rr_wdata", 32'(reg_wdata), 32'(8'hA0 + (k % 4)));
        end

        // Locked burst by requester 1 while 0 and 2 compete
        clear_all();
        set_req(0, 1'b1, 0, 8'h00, 1'b0);
        set_req(2, 1'b1, 2, 8'h22, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_req(1, 1'b1, 1, 8'h10 + b, b < 3);
            tick();
            check_eq("lock_gnt", 32'(last_ready), 32'h2);
            check_eq("lock_busy", 32'(busy_locked), (b < 3) ? 32'd1 : 32'd0);
        end
        tick();
        check_eq("lock_next", 32'(last_ready), 32'h4);

        // Owner gap: requester 3 locks, drops valid, returns
        clear_all();
        set_req(3, 1'b1, 3, 8'h33, 1'b1);
        tick();
        check_eq("gap_gnt", 32'(last_ready), 32'h8);
        set_req(3, 1'b0, 3, 8'h34, 1'b1);
        set_req(0, 1'b1, 0, 8'h01, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("gap_ready", 32'(last_ready), 32'd0);
            check_eq("gap_we", 32'(reg_we), 32'd0);
            check_eq("gap_busy", 32'(busy_locked), 32'd1);
        end
        set_req(3, 1'b1, 3, 8'h35, 1'b0);
        tick();
        check_eq("gap_back", 32'(last_ready), 32'h8);
        check_eq("gap_wdata", 32'(reg_wdata), 32'h35);

        // Out-of-range address
        clear_all();
        set_req(0, 1'b1, 6, 8'h55, 1'b0);
        tick();
        check_eq("oor_gnt", 32'(last_ready), 32'h1);
        check_eq("oor_we", 32'(reg_we), 32'd0);
        check_eq("oor_err", 32'(err_oor), 32'd1);
        set_req(0, 1'b1, 0, 8'h60, 1'b0);
        set_req(1, 1'b1, 1, 8'h61, 1'b0);
        tick();
        check_eq("oor_ptr", 32'(last_ready), 32'h2);
        check_eq("oor_clr", 32'(err_oor), 32'd0);

        // Single requester sustains one beat per cycle
        clear_all();
        for (int c = 0; c < 8; c++) begin
            set_req(2, 1'b1, 4, $urandom_range(0, 255), 1'b0);
            tick();
            check_eq("single_gnt", 32'(last_ready), 32'h4);
            check_eq("single_we", 32'(reg_we), 32'h10);
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NQ; i++) begin
                set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                        $urandom_range(0, 255), $urandom_range(0, 2) == 0);
            end
            tick();
        end

        // Asynchronous reset with a beat in flight
        for (int i = 0; i < NQ; i++) set_req(i, 1'b1, i, 8'hC0 + i, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_we", 32'(reg_we), 32'd0);
        check_eq("arst_wdata", 32'(reg_wdata), 32'd0);
        check_eq("arst_err", 32'(err_oor), 32'd0);
        check_eq("arst_busy", 32'(busy_locked), 32'd0);
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        check_eq("arst_nowrite", 32'(reg_we), 32'd0);
        for (int i = 0; i < NQ; i++) set_req(i, 1'b1, i, 8'hD0 + i, 1'b0);
        tick();
        check_eq("arst_first", 32'(last_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
